// File: rtl/fproc_arbiter_pkg.sv
// Shared definitions for the function-processor arbiter.
// Holds the FSM state encoding and the data word returned on a timed-out
// transaction. The timeout word is 64 bits wide and is truncated to the
// arbiter's DATA_WIDTH (DATA_WIDTH is expected to be <= 64).
package fproc_arbiter_pkg;

    typedef enum logic [1:0] {
        FPA_IDLE  = 2'd0,
        FPA_ISSUE = 2'd1,
        FPA_WAIT  = 2'd2,
        FPA_DONE  = 2'd3
    } fpa_state_e;

    localparam logic [63:0] FPA_TIMEOUT_DATA = '1;

endpackage

// File: rtl/fproc_arbiter_rr_arbiter.sv
// Combinational round-robin priority select.
// Picks the first set bit of pending_i at or after ptr_i, wrapping modulo N.
// Ports:
//   pending_i  N-bit request vector
//   ptr_i      round-robin start index (always < N)
//   grant_o    index of the selected requester (0 when none pending)
//   any_o      at least one request is pending
module fproc_arbiter_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     pending_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] grant_o,
    output logic             any_o
);

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) s = s - N;
        return IDX_W'(s);
    endfunction

    // Scan from the farthest offset down so the nearest pending index wins.
    always_comb begin
        grant_o = '0;
        any_o   = |pending_i;
        for (int k = N - 1; k >= 0; k--) begin
            if (pending_i[wrap_idx(ptr_i, k)]) grant_o = wrap_idx(ptr_i, k);
        end
    end

endmodule

// File: rtl/fproc_arbiter.sv
// Shares one function processor (fproc) among N_CORES cores.
// Per-core requests are latched, granted round-robin, issued to the fproc
// with a valid/ready request handshake, and completed by a response strobe
// or by a timeout. The result returns to the core with a one-cycle ready.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   core_fproc_en/id      per-core request strobe/level and packed ids
//   core_fproc_ready      one-cycle completion pulse per core
//   core_fproc_data       result, qualified by any core_fproc_ready bit
//   fproc_req_*           request channel to the fproc
//   fproc_resp_*          response channel from the fproc
//   busy                  transaction in progress
//   timeout_err           sticky timeout flag
module fproc_arbiter
    import fproc_arbiter_pkg::*;
#(
    parameter int N_CORES        = 4,
    parameter int ID_WIDTH       = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int CORE_IDX_WIDTH = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_CORES-1:0]           core_fproc_en,
    input  logic [N_CORES*ID_WIDTH-1:0]  core_fproc_id,
    output logic [N_CORES-1:0]           core_fproc_ready,
    output logic [DATA_WIDTH-1:0]        core_fproc_data,
    output logic                         fproc_req_valid,
    output logic [ID_WIDTH-1:0]          fproc_req_id,
    output logic [CORE_IDX_WIDTH-1:0]    fproc_req_core,
    input  logic                         fproc_req_ready,
    input  logic                         fproc_resp_valid,
    input  logic [DATA_WIDTH-1:0]        fproc_resp_data,
    output logic                         busy,
    output logic                         timeout_err
);

    fpa_state_e                            state_q, state_d;
    logic [N_CORES-1:0]                    pending_q, pending_d;
    logic [N_CORES-1:0]                    block_q, block_d;
    logic [N_CORES-1:0][ID_WIDTH-1:0]      id_q, id_d;
    logic [CORE_IDX_WIDTH-1:0]             grant_q, grant_d;
    logic [CORE_IDX_WIDTH-1:0]             rr_q, rr_d;
    logic [15:0]                           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]                 data_q, data_d;
    logic                                  terr_q, terr_d;

    logic [CORE_IDX_WIDTH-1:0]             arb_grant;
    logic                                  arb_any;
    logic [N_CORES-1:0]                    done_mask;

    fproc_arbiter_rr_arbiter #(
        .N     (N_CORES),
        .IDX_W (CORE_IDX_WIDTH)
    ) u_rr (
        .pending_i (pending_q),
        .ptr_i     (rr_q),
        .grant_o   (arb_grant),
        .any_o     (arb_any)
    );

    assign done_mask = (state_q == FPA_DONE) ? (N_CORES'(1) << grant_q) : '0;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        id_d      = id_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        terr_d    = terr_q;
        // A core is blocked in its ready cycle and the cycle after, so a
        // level-held en during core turnaround cannot re-arm a request.
        block_d   = done_mask;

        for (int i = 0; i < N_CORES; i++) begin
            if (core_fproc_en[i] && !pending_q[i] && !(done_mask[i] || block_q[i])) begin
                pending_d[i] = 1'b1;
                id_d[i]      = core_fproc_id[i*ID_WIDTH +: ID_WIDTH];
            end
        end

        case (state_q)
            FPA_IDLE: begin
                if (arb_any) begin
                    grant_d = arb_grant;
                    state_d = FPA_ISSUE;
                end
            end
            FPA_ISSUE: begin
                if (fproc_req_ready) begin
                    cnt_d   = '0;
                    state_d = FPA_WAIT;
                end
            end
            FPA_WAIT: begin
                if (fproc_resp_valid) begin
                    data_d  = fproc_resp_data;
                    state_d = FPA_DONE;
                end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    data_d  = DATA_WIDTH'(FPA_TIMEOUT_DATA);
                    terr_d  = 1'b1;
                    state_d = FPA_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            FPA_DONE: begin
                pending_d[grant_q] = 1'b0;
                rr_d    = (grant_q == CORE_IDX_WIDTH'(N_CORES - 1)) ? '0
                                                                    : grant_q + CORE_IDX_WIDTH'(1);
                state_d = FPA_IDLE;
            end
            default: state_d = FPA_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FPA_IDLE;
            pending_q <= '0;
            block_q   <= '0;
            id_q      <= '0;
            grant_q   <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            block_q   <= block_d;
            id_q      <= id_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            terr_q    <= terr_d;
        end
    end

    assign core_fproc_ready = done_mask;
    assign core_fproc_data  = data_q;
    assign fproc_req_valid  = (state_q == FPA_ISSUE);
    assign fproc_req_id     = id_q[grant_q];
    assign fproc_req_core   = grant_q;
    assign busy             = (state_q != FPA_IDLE);
    assign timeout_err      = terr_q;

endmodule

// File: tb/tb_fproc_arbiter.sv
`timescale 1ns/1ps
module tb_fproc_arbiter;

    localparam int N  = 4;
    localparam int IW = 8;
    localparam int DW = 32;
    localparam int CW = 2;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    en = '0;
    logic [N*IW-1:0] ids = '0;
    logic [N-1:0]    rdy;
    logic [DW-1:0]   dout;
    logic            rq_v;
    logic [IW-1:0]   rq_id;
    logic [CW-1:0]   rq_core;
    logic            rq_rdy = 1'b0;
    logic            rs_v = 1'b0;
    logic [DW-1:0]   rs_d = '0;
    logic            busy;
    logic            terr;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fproc_arbiter #(
        .N_CORES        (N),
        .ID_WIDTH       (IW),
        .DATA_WIDTH     (DW),
        .CORE_IDX_WIDTH (CW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .core_fproc_en    (en),
        .core_fproc_id    (ids),
        .core_fproc_ready (rdy),
        .core_fproc_data  (dout),
        .fproc_req_valid  (rq_v),
        .fproc_req_id     (rq_id),
        .fproc_req_core   (rq_core),
        .fproc_req_ready  (rq_rdy),
        .fproc_resp_valid (rs_v),
        .fproc_resp_data  (rs_d),
        .busy             (busy),
        .timeout_err      (terr)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // m_cur: core being served (-1 none); m_acc: request accepted by fproc;
    // m_fin: result known, ready shown this cycle; m_waited: response wait count.
    bit            m_pend[N];
    logic [IW-1:0] m_id[N];
    int            m_lastrdy[N];
    int            m_cur = -1;
    bit            m_acc = 0;
    bit            m_fin = 0;
    bit            m_terr = 0;
    int            m_waited = 0;
    logic [DW-1:0] m_data = '0;
    int            m_rr = 0;
    int            now = 0;

    initial begin
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_id[i] = '0; m_lastrdy[i] = -100;
        end
    end

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_id[i] = '0; m_lastrdy[i] = -100;
        end
        m_cur = -1; m_acc = 0; m_fin = 0; m_terr = 0; m_waited = 0; m_data = '0; m_rr = 0;
    endtask

    task automatic model_step();
        bit np[N];
        np = m_pend;
        if (m_fin) m_lastrdy[m_cur] = now;
        for (int i = 0; i < N; i++) begin
            if (en[i] && !m_pend[i] && (now - m_lastrdy[i]) > 1) begin
                np[i] = 1;
                m_id[i] = ids[i*IW +: IW];
            end
        end
        if (m_cur < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_cur < 0 && m_pend[(m_rr + k) % N]) m_cur = (m_rr + k) % N;
            end
            m_acc = 0;
        end else if (!m_acc) begin
            if (rq_rdy) begin m_acc = 1; m_waited = 0; end
        end else if (!m_fin) begin
            if (rs_v) begin
                m_data = rs_d; m_fin = 1;
            end else if (m_waited == TO - 1) begin
                m_data = '1; m_terr = 1; m_fin = 1;
            end else begin
                m_waited++;
            end
        end else begin
            np[m_cur] = 0;
            m_rr = (m_cur + 1) % N;
            m_cur = -1; m_acc = 0; m_fin = 0;
        end
        m_pend = np;
        now++;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_clear();
        else model_step();
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [N-1:0] er;
        er = m_fin ? (N'(1) << m_cur) : '0;
        chk("busy", busy, m_cur >= 0);
        chk("req_valid", rq_v, (m_cur >= 0) && !m_acc);
        if (m_cur >= 0 && !m_acc) begin
            chk("req_id", rq_id, m_id[m_cur]);
            chk("req_core", rq_core, 64'(m_cur));
        end
        chk("ready", rdy, er);
        chk("data", dout, m_data);
        chk("timeout_err", terr, m_terr);
    end

    // ---------------- directed + random stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en = '0; rq_rdy = 0; rs_v = 0;
        reset = 0;
        cyc(2);
        reset = 1;
        cyc(1);
    endtask

    task automatic wait_valid(input string nm);
        for (int k = 0; k < 60; k++) begin
            if (rq_v) break;
            cyc(1);
        end
        chk(nm, rq_v, 1'b1);
    endtask

    task automatic wait_ready(input string nm);
        for (int k = 0; k < 60; k++) begin
            if (rdy != 0) break;
            cyc(1);
        end
        chk(nm, rdy != 0, 1'b1);
    endtask

    initial begin
        int order[$];
        int exp_order[4];
        int pulses;
        int w;
        bit injected;
        logic [IW-1:0] hold_id;
        logic [CW-1:0] hold_core;

        do_reset();

        // single request
        rq_rdy = 1;
        en[1] = 1; ids[1*IW +: IW] = 8'h2A;
        cyc(1); en[1] = 0;
        wait_valid("t1_valid_wait");
        chk("t1_req_id", rq_id, 8'h2A);
        chk("t1_req_core", rq_core, 1);
        cyc(3);
        rs_v = 1; rs_d = 32'hDEADBEEF;
        cyc(1); rs_v = 0;
        wait_ready("t1_ready_wait");
        chk("t1_ready_vec", rdy, 4'b0010);
        chk("t1_data", dout, 32'hDEADBEEF);
        cyc(1);
        chk("t1_single_pulse", rdy, 4'b0000);
        chk("t1_busy_idle", busy, 1'b0);

        // contention with a late core 0 request
        do_reset();
        rq_rdy = 1; rs_v = 1; rs_d = 32'h0000C0DE;
        ids = {8'h03, 8'h02, 8'h01, 8'h00};
        en = 4'b1101;
        cyc(1); en = '0;
        injected = 0;
        for (int k = 0; k < 60 && order.size() < 4; k++) begin
            if (rdy != 0) begin
                for (int i = 0; i < N; i++) if (rdy[i]) order.push_back(i);
            end
            if (!injected && rq_v && rq_core == 2'd3) begin
                en[0] = 1; injected = 1;
            end else begin
                en[0] = 0;
            end
            cyc(1);
        end
        en = '0;
        exp_order = '{0, 2, 3, 0};
        chk("t2_count", order.size(), 4);
        for (int i = 0; i < order.size() && i < 4; i++) chk("t2_order", order[i], exp_order[i]);
        rs_v = 0;
        cyc(3);

        // backpressure; responses outside WAIT_RESP ignored
        rq_rdy = 0;
        en[1] = 1; ids[1*IW +: IW] = 8'h55;
        cyc(1); en[1] = 0;
        wait_valid("t3_valid_wait");
        hold_id = rq_id; hold_core = rq_core;
        chk("t3_id", hold_id, 8'h55);
        for (int k = 0; k < 10; k++) begin
            chk("t3_valid_held", rq_v, 1'b1);
            chk("t3_id_held", rq_id, hold_id);
            chk("t3_core_held", rq_core, hold_core);
            rs_v = (k % 3 == 0); rs_d = 32'h0BAD0BAD;
            cyc(1);
        end
        rq_rdy = 1; rs_v = 1; rs_d = 32'h0BADBEEF;
        cyc(1);
        rq_rdy = 0; rs_v = 0;
        cyc(3);
        chk("t3_no_early_ready", rdy, 4'b0000);
        chk("t3_valid_dropped", rq_v, 1'b0);
        rs_v = 1; rs_d = 32'h12345678;
        cyc(1); rs_v = 0;
        wait_ready("t3_ready_wait");
        chk("t3_data", dout, 32'h12345678);
        cyc(2);

        // level-held en through the block window
        rq_rdy = 1; rs_v = 1; rs_d = 32'h00000222;
        en[2] = 1; ids[2*IW +: IW] = 8'h22;
        wait_ready("t4_ready_wait");
        chk("t4_ready_vec", rdy, 4'b0100);
        cyc(2);
        en[2] = 0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (rdy != 0) pulses++;
            cyc(1);
        end
        chk("t4_one_transaction", pulses, 0);
        en[2] = 1;
        cyc(1); en[2] = 0;
        wait_ready("t4_second_wait");
        chk("t4_second_vec", rdy, 4'b0100);
        rs_v = 0;
        cyc(2);

        // timeout
        rq_rdy = 1; rs_v = 0;
        en[3] = 1; ids[3*IW +: IW] = 8'h33;
        cyc(1); en[3] = 0;
        wait_valid("t5_valid_wait");
        cyc(1);
        w = 0;
        while (rdy == 0 && w < 40) begin
            w++;
            cyc(1);
        end
        chk("t5_wait_cycles", w, TO);
        chk("t5_data", dout, 32'hFFFFFFFF);
        chk("t5_ready_vec", rdy, 4'b1000);
        chk("t5_terr", terr, 1'b1);
        rs_v = 1; rs_d = 32'hA5A50001;
        en[0] = 1; ids[0*IW +: IW] = 8'h44;
        cyc(1); en[0] = 0;
        wait_ready("t5_next_wait");
        chk("t5_next_data", dout, 32'hA5A50001);
        chk("t5_terr_sticky", terr, 1'b1);
        rs_v = 0;
        cyc(2);

        // asynchronous reset during WAIT_RESP
        rq_rdy = 1; rs_v = 0;
        en[1] = 1; ids[1*IW +: IW] = 8'h61;
        wait_valid("t6_valid_wait");
        cyc(2);
        #2 reset = 0;
        #1;
        chk("t6_busy", busy, 1'b0);
        chk("t6_valid", rq_v, 1'b0);
        chk("t6_ready", rdy, 4'b0000);
        chk("t6_data", dout, 32'h0);
        chk("t6_terr", terr, 1'b0);
        cyc(2);
        reset = 1;
        wait_valid("t6_relatch_wait");
        chk("t6_relatch_core", rq_core, 1);
        chk("t6_relatch_id", rq_id, 8'h61);
        en[1] = 0; rs_v = 1; rs_d = 32'h00006161;
        wait_ready("t6_done_wait");
        chk("t6_done_vec", rdy, 4'b0010);
        rs_v = 0;
        cyc(2);

        // randomized traffic against the model
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < N; i++) begin
                en[i] = ($urandom_range(0, 99) < 15);
                ids[i*IW +: IW] = IW'($urandom);
            end
            rq_rdy = $urandom_range(0, 1);
            rs_v = ($urandom_range(0, 3) == 0);
            rs_d = $urandom;
            cyc(1);
        end
        en = '0; rq_rdy = 1; rs_v = 1;
        cyc(60);
        chk("drain_idle", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
